// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared refill state type, default geometry and helpers for the icache refill controller
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_WRITE     = 2'd3
  } refill_state_t;

  localparam int DEF_PC_SIZE    = 32;
  localparam int DEF_BLOCK_SIZE = 128;
  localparam int DEF_BUS_WIDTH  = 32;
  localparam int BEATS          = DEF_BLOCK_SIZE / DEF_BUS_WIDTH;
  localparam int BEAT_CNT_W     = $clog2(BEATS);

  // Number of byte-offset bits inside one cache line.
  function automatic int line_off_w(input int block_size);
    return $clog2(block_size / 8);
  endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - beat-indexed line assembly buffer; slot 0 lands at the leftmost bits of block_o
module icache_line_buffer
  import icache_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int NBEATS    = BEATS,
  parameter int CNT_W     = BEAT_CNT_W
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          wr_en_i,
  input  logic [CNT_W-1:0]              slot_i,
  input  logic [BUS_WIDTH-1:0]          wdata_i,
  output logic [0:NBEATS*BUS_WIDTH-1]   block_o
);

  logic [BUS_WIDTH-1:0] slot_q [NBEATS];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < NBEATS; k++) slot_q[k] <= '0;
    end else if (wr_en_i) begin
      slot_q[slot_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < NBEATS; k++) begin : g_slot
    assign block_o[k*BUS_WIDTH +: BUS_WIDTH] = slot_q[k];
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache miss/refill FSM: stalls fetch, reads a line from IRAM, writes it into the cache.
// Optional miss/stall performance counters with ICACHE_PERF_CNT_EN.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int PC_SIZE    = DEF_PC_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [PC_SIZE-1:0]    pc,
  input  logic                  fetch_req,
  input  logic                  hit,
  input  logic                  flush,
  output logic                  stall,
  output logic                  cache_we,
  output logic [0:BLOCK_SIZE-1] block_out,
  output logic                  mem_req,
  output logic [PC_SIZE-1:0]    mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           miss_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int NBEATS = BLOCK_SIZE / BUS_WIDTH;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = line_off_w(BLOCK_SIZE);
  localparam logic [PC_SIZE-1:0] LINE_MASK = ~((PC_SIZE'(1) << OFF_W) - PC_SIZE'(1));

  refill_state_t        state_q, state_d;
  logic [PC_SIZE-1:0]   line_addr_q, line_addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 miss, last_beat, beat_we;

  assign miss      = fetch_req & ~hit;
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
  assign beat_we   = (state_q == ST_WAIT_DATA) & mem_rvalid;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d     = ST_REQ;
          line_addr_d = pc & LINE_MASK;
          cnt_d       = '0;
          drop_d      = 1'b0;
        end
      end
      ST_REQ: begin
        // A grant wins over a same-cycle flush: the IRAM is committed, so the line is drained and dropped.
        if (mem_gnt) begin
          state_d = ST_WAIT_DATA;
          drop_d  = flush;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        drop_d = drop_q | flush;
        if (mem_rvalid) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = (drop_q | flush) ? ST_IDLE : ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign stall    = (state_q != ST_IDLE) | miss;
  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = line_addr_q;
  assign cache_we = (state_q == ST_WRITE);

  icache_line_buffer #(
    .BUS_WIDTH (BUS_WIDTH),
    .NBEATS    (NBEATS),
    .CNT_W     (CNT_W)
  ) u_line_buffer (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en_i (beat_we),
    .slot_i  (cnt_q),
    .wdata_i (mem_rdata),
    .block_o (block_out)
  );

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] miss_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign miss_cnt  = miss_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl with directed and randomized refills
module tb_icache_refill_ctrl;

  logic         clk;
  logic         nrst;
  logic [31:0]  pc;
  logic         fetch_req, hit, flush;
  logic         stall, cache_we;
  logic [0:127] block_out;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt, mem_rvalid;
  logic [31:0]  mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  miss_cnt, stall_cnt;
`endif

  int           n_assert = 0;
  int           n_fail   = 0;
  int           we_count = 0;
  int           we0_main;
  logic [127:0] last_block;
  logic [31:0]  beat_data [4];

  icache_refill_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .hit        (hit),
    .flush      (flush),
    .stall      (stall),
    .cache_we   (cache_we),
    .block_out  (block_out),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .miss_cnt   (miss_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cache write is recorded mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (cache_we === 1'b1) begin
      we_count   = we_count + 1;
      last_block = block_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fmode: 0 none, 1 flush in REQ before grant, 2 flush after beat 1, 3 flush with grant.
  task automatic refill(input logic [31:0] pc_v, input int gdel, input int gap, input int fmode);
    int           we0, st, exp_st;
    logic         drop;
    logic [127:0] exp_line;
    logic [31:0]  exp_addr;
    exp_line = {beat_data[0], beat_data[1], beat_data[2], beat_data[3]};
    exp_addr = pc_v - (pc_v % 32'd16);
    drop     = (fmode != 0);
    we0      = we_count;
    st       = 0;
    pc = pc_v; fetch_req = 1'b1; hit = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    st += int'(stall);
    check("miss_stall", 128'(stall), 128'(1'b1));
    check("miss_mem_req", 128'(mem_req), 128'(1'b0));
    tick();
    for (int i = 0; i <= gdel; i++) begin
      mem_gnt = (i == gdel);
      flush   = (fmode == 1 && i == gdel - 1) || (fmode == 3 && i == gdel);
      #1;
      st += int'(stall);
      check("req_mem_req", 128'(mem_req), 128'(1'b1));
      check("req_mem_addr", 128'(mem_addr), 128'(exp_addr));
      tick();
      if (fmode == 1 && i == gdel - 1) begin
        flush = 1'b0; fetch_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          check("flushreq_mem_req", 128'(mem_req), 128'(1'b0));
          check("flushreq_stall", 128'(stall), 128'(1'b0));
          tick();
        end
        check("flushreq_we_count", 128'(we_count - we0), 128'(0));
        return;
      end
    end
    mem_gnt = 1'b0;
    if (fmode == 3) begin flush = 1'b0; fetch_req = 1'b0; end
    for (int b = 0; b < 4; b++) begin
      int ncyc;
      ncyc = (b == 0) ? 1 : gap + 1;
      for (int c = 0; c < ncyc; c++) begin
        mem_rvalid = (c == ncyc - 1);
        mem_rdata  = mem_rvalid ? beat_data[b] : $urandom;
        flush      = (fmode == 2 && b == 2 && c == 0);
        #1;
        st += int'(stall);
        check("beat_stall", 128'(stall), 128'(1'b1));
        check("beat_cache_we", 128'(cache_we), 128'(1'b0));
        check("beat_mem_req", 128'(mem_req), 128'(1'b0));
        tick();
        if (flush) begin flush = 1'b0; fetch_req = 1'b0; end
      end
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    #1;
    st += int'(stall);
    exp_st = 1 + (gdel + 1) + 4 + 3 * gap;
    if (drop) begin
      check("drop_cache_we", 128'(cache_we), 128'(1'b0));
      check("drop_stall", 128'(stall), 128'(1'b0));
    end else begin
      exp_st += 1;
      check("write_cache_we", 128'(cache_we), 128'(1'b1));
      check("write_stall", 128'(stall), 128'(1'b1));
      check("write_block", 128'(block_out), exp_line);
      tick();
      hit = 1'b1;
      #1;
      check("after_cache_we", 128'(cache_we), 128'(1'b0));
      check("after_stall", 128'(stall), 128'(1'b0));
    end
    check("stall_cycles", 128'(st), 128'(exp_st));
    check("we_count", 128'(we_count - we0), 128'(drop ? 0 : 1));
    if (!drop) check("we_block", last_block, exp_line);
    tick();
  endtask

  initial begin
    nrst = 1'b0; pc = '0; fetch_req = 1'b0; hit = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst_mem_req", 128'(mem_req), 128'(1'b0));
    check("rst_cache_we", 128'(cache_we), 128'(1'b0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_block_out", 128'(block_out), 128'(0));
    check("rst_stall_idle", 128'(stall), 128'(1'b0));
    fetch_req = 1'b1; hit = 1'b0;
    #1;
    check("rst_stall_miss", 128'(stall), 128'(1'b1));
    tick();
    nrst = 1'b1;

    beat_data[0] = 32'h1111_1111; beat_data[1] = 32'h2222_2222;
    beat_data[2] = 32'h3333_3333; beat_data[3] = 32'h4444_4444;
    refill(32'h0000_1234, 0, 0, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_miss_cnt", 128'(miss_cnt), 128'(1));
    check("perf_stall_cnt", 128'(stall_cnt), 128'(7));
`endif

    we0_main = we_count;
    for (int i = 0; i < 10; i++) begin
      pc = $urandom; fetch_req = 1'b1; hit = 1'b1; flush = 1'($urandom);
      mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      #1;
      check("hit_stall", 128'(stall), 128'(1'b0));
      check("hit_mem_req", 128'(mem_req), 128'(1'b0));
      check("hit_cache_we", 128'(cache_we), 128'(1'b0));
      tick();
    end
    flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("hit_we_count", 128'(we_count - we0_main), 128'(0));

    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    refill(32'h0040_00fc, 3, 1, 0);
    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    refill(32'h0000_2008, 2, 0, 1);
    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    refill(32'h0000_300c, 0, 0, 2);
    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    refill(32'h0000_4004, 1, 1, 3);

    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    we0_main = we_count;
    pc = 32'h0000_8014; fetch_req = 1'b1; hit = 1'b0; flush = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1; mem_rdata = beat_data[b];
      tick();
    end
    mem_rvalid = 1'b0; nrst = 1'b0; fetch_req = 1'b0;
    tick();
    nrst = 1'b1;
    #1;
    check("midrst_mem_req", 128'(mem_req), 128'(1'b0));
    check("midrst_cache_we", 128'(cache_we), 128'(1'b0));
    check("midrst_stall", 128'(stall), 128'(1'b0));
    check("midrst_block_out", 128'(block_out), 128'(0));
    check("midrst_mem_addr", 128'(mem_addr), 128'(0));
    tick();
    tick();
    check("midrst_we_count", 128'(we_count - we0_main), 128'(0));
    for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
    refill(32'h0000_8014, 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      int gd, gp, fm;
      gd = int'($urandom_range(0, 3));
      gp = int'($urandom_range(0, 2));
      fm = int'($urandom_range(0, 3));
      if (fm == 1 && gd == 0) gd = 1;
      for (int b = 0; b < 4; b++) beat_data[b] = $urandom;
      refill($urandom, gd, gp, fm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
